// File: rtl/opsum_drain_ctrl.sv
// Round-robin drain of NUM_CH 2-entry opsum FIFOs into a single 32-bit GLB write port.
// Optional: define OPSUM_DRAIN_PERF_EN to add perf_stall_cnt / perf_word_cnt outputs.

module opsum_drain_lane #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] base,
  input  logic              adv,
  input  logic              adv_word,
  input  logic              full,
  input  logic              empty,
  input  logic              flush,
  output logic [ADDR_W-1:0] addr,
  output logic              elig,
  output logic              can_word
);
  logic [ADDR_W-1:0] addr_d, addr_q;

  always_comb begin
    addr_d = addr_q;
    if (load)     addr_d = base;
    else if (adv) addr_d = addr_q + (adv_word ? ADDR_W'(4) : ADDR_W'(2));
  end

  always_ff @(posedge clk) begin
    if (rst) addr_q <= '0;
    else     addr_q <= addr_d;
  end

  assign addr     = addr_q;
  assign elig     = full | (flush & ~empty);
  // A misaligned full FIFO drains one halfword first, which realigns it.
  assign can_word = full & ~addr_q[1];
endmodule

module opsum_drain_ctrl #(
  parameter int NUM_CH = 4,
  parameter int ADDR_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     flush,
  input  logic [NUM_CH*ADDR_W-1:0] ch_base_addr,
  input  logic [NUM_CH-1:0]        fifo_full,
  input  logic [NUM_CH-1:0]        fifo_empty,
  output logic [NUM_CH-1:0]        fifo_pop_en,
  output logic [NUM_CH-1:0]        fifo_pop_mod,
  input  logic [NUM_CH*32-1:0]     fifo_pop_data,
  output logic                     glb_wr_valid,
  input  logic                     glb_wr_ready,
  output logic [ADDR_W-1:0]        glb_wr_addr,
  output logic [31:0]              glb_wr_data,
  output logic [3:0]               glb_wr_strb,
  output logic                     busy,
  output logic                     done
`ifdef OPSUM_DRAIN_PERF_EN
  ,
  output logic [31:0]              perf_stall_cnt,
  output logic [31:0]              perf_word_cnt
`endif
);
  localparam int CH_W = $clog2(NUM_CH);

  typedef enum logic [2:0] {S_IDLE, S_ARB, S_POP, S_LATCH, S_WRITE} state_e;

  state_e            state_q, state_d;
  logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CH_W-1:0]   gnt_q, gnt_d;
  logic              mode_q, mode_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;

  logic [NUM_CH-1:0][ADDR_W-1:0] base_a, addr_a;
  logic [NUM_CH-1:0][31:0]       pop_data_a;
  logic [NUM_CH-1:0]             elig, can_word, lane_adv;
  logic                          load, adv;
  logic [CH_W:0]                 pick;
  logic [ADDR_W-1:0]             gnt_addr;
  logic [31:0]                   gnt_data;

  assign base_a     = ch_base_addr;
  assign pop_data_a = fifo_pop_data;

  genvar i;
  generate
    for (i = 0; i < NUM_CH; i++) begin : g_lane
      assign lane_adv[i] = adv && (gnt_q == CH_W'(i));
      opsum_drain_lane #(.ADDR_W(ADDR_W)) u_lane (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .base     (base_a[i]),
        .adv      (lane_adv[i]),
        .adv_word (mode_q),
        .full     (fifo_full[i]),
        .empty    (fifo_empty[i]),
        .flush    (flush),
        .addr     (addr_a[i]),
        .elig     (elig[i]),
        .can_word (can_word[i])
      );
    end
  endgenerate

  // {found, index} of the first requester at or after ptr, wrapping.
  function automatic logic [CH_W:0] rr_pick(input logic [NUM_CH-1:0] req,
                                            input logic [CH_W-1:0]   ptr);
    logic [CH_W:0]   res;
    logic [CH_W-1:0] idx;
    res = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      idx = CH_W'((int'(ptr) + k) % NUM_CH);
      if (req[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  assign pick     = rr_pick(elig, rr_ptr_q);
  assign gnt_addr = addr_a[gnt_q];
  assign gnt_data = pop_data_a[gnt_q];

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    gnt_d    = gnt_q;
    mode_d   = mode_q;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    load     = 1'b0;
    adv      = 1'b0;
    done     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = S_ARB;
        end
      end
      S_ARB: begin
        if (pick[CH_W]) begin
          gnt_d   = pick[CH_W-1:0];
          mode_d  = can_word[pick[CH_W-1:0]];
          state_d = S_POP;
        end else if (flush) begin
          done    = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_POP:   state_d = S_LATCH;
      S_LATCH: begin
        waddr_d = {gnt_addr[ADDR_W-1:2], 2'b00};
        if (mode_q) begin
          wdata_d = gnt_data;
          wstrb_d = 4'b1111;
        end else if (gnt_addr[1]) begin
          wdata_d = {gnt_data[15:0], 16'd0};
          wstrb_d = 4'b1100;
        end else begin
          wdata_d = {16'd0, gnt_data[15:0]};
          wstrb_d = 4'b0011;
        end
        state_d = S_WRITE;
      end
      S_WRITE: begin
        if (glb_wr_ready) begin
          adv      = 1'b1;
          rr_ptr_d = (gnt_q == CH_W'(NUM_CH - 1)) ? '0 : gnt_q + 1'b1;
          state_d  = S_ARB;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= '0;
      gnt_q    <= '0;
      mode_q   <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      gnt_q    <= gnt_d;
      mode_q   <= mode_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
    end
  end

  always_comb begin
    fifo_pop_en  = '0;
    fifo_pop_mod = '0;
    if (state_q == S_POP) begin
      fifo_pop_en[gnt_q]  = 1'b1;
      fifo_pop_mod[gnt_q] = mode_q;
    end
  end

  assign glb_wr_valid = (state_q == S_WRITE);
  assign glb_wr_addr  = waddr_q;
  assign glb_wr_data  = wdata_q;
  assign glb_wr_strb  = wstrb_q;
  assign busy         = (state_q != S_IDLE);

`ifdef OPSUM_DRAIN_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] word_cnt_q, word_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    word_cnt_d  = word_cnt_q;
    if (load) begin
      stall_cnt_d = '0;
      word_cnt_d  = '0;
    end else begin
      if (glb_wr_valid && !glb_wr_ready && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 32'd1;
      if (glb_wr_valid && glb_wr_ready && word_cnt_q != '1)   word_cnt_d  = word_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      word_cnt_q  <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      word_cnt_q  <= word_cnt_d;
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_word_cnt  = word_cnt_q;
`endif
endmodule

// File: tb/tb_opsum_drain_ctrl.sv
// Directed bench for opsum_drain_ctrl: 2-entry FIFO models feed the DUT, GLB writes go to a scoreboard.
module tb_opsum_drain_ctrl;
  localparam int NCH = 4;
  localparam int AW  = 32;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
  } wr_t;

  logic                     clk = 1'b0;
  logic                     rst, start, flush;
  logic [NCH-1:0][AW-1:0]   base_a;
  logic [NCH-1:0]           fifo_full, fifo_empty, fifo_pop_en, fifo_pop_mod;
  logic [NCH-1:0][31:0]     pop_data_a = '0;
  logic                     glb_wr_valid, glb_wr_ready;
  logic [AW-1:0]            glb_wr_addr;
  logic [31:0]              glb_wr_data;
  logic [3:0]               glb_wr_strb;
  logic                     busy, done;
`ifdef OPSUM_DRAIN_PERF_EN
  logic [31:0]              perf_stall_cnt, perf_word_cnt;
`endif

  logic [NCH-1:0]           push_mask = '0;
  logic [NCH-1:0][15:0]     push_val  = '0;
  logic [NCH-1:0][1:0]      cnt = '0;
  logic [NCH-1:0][15:0]     e0 = '0, e1 = '0;

  wr_t exp_q[$];
  int  pass_cnt  = 0;
  int  total_cnt = 0;

  always #5 clk = ~clk;

  opsum_drain_ctrl #(.NUM_CH(NCH), .ADDR_W(AW)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .flush         (flush),
    .ch_base_addr  (base_a),
    .fifo_full     (fifo_full),
    .fifo_empty    (fifo_empty),
    .fifo_pop_en   (fifo_pop_en),
    .fifo_pop_mod  (fifo_pop_mod),
    .fifo_pop_data (pop_data_a),
    .glb_wr_valid  (glb_wr_valid),
    .glb_wr_ready  (glb_wr_ready),
    .glb_wr_addr   (glb_wr_addr),
    .glb_wr_data   (glb_wr_data),
    .glb_wr_strb   (glb_wr_strb),
    .busy          (busy),
    .done          (done)
`ifdef OPSUM_DRAIN_PERF_EN
    ,
    .perf_stall_cnt(perf_stall_cnt),
    .perf_word_cnt (perf_word_cnt)
`endif
  );

  always_comb begin
    fifo_full  = '0;
    fifo_empty = '0;
    for (int i = 0; i < NCH; i++) begin
      fifo_full[i]  = (cnt[i] == 2'd2);
      fifo_empty[i] = (cnt[i] == 2'd0);
    end
  end

  // FIFO model: registered pop data; 16-bit pops put junk in the upper half.
  always @(posedge clk) begin
    for (int i = 0; i < NCH; i++) begin
      if (fifo_pop_en[i]) begin
        if (fifo_pop_mod[i]) begin
          pop_data_a[i] <= {e1[i], e0[i]};
          cnt[i]        <= 2'd0;
        end else begin
          pop_data_a[i] <= {16'hDEAD, e0[i]};
          e0[i]         <= e1[i];
          cnt[i]        <= cnt[i] - 2'd1;
        end
      end else if (push_mask[i]) begin
        if (cnt[i] == 2'd0) e0[i] <= push_val[i];
        else                e1[i] <= push_val[i];
        cnt[i] <= cnt[i] + 2'd1;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [NCH-1:0] m, input logic [NCH-1:0][15:0] v);
    push_mask = m;
    push_val  = v;
    tick();
    push_mask = '0;
  endtask

  task automatic expect_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    wr_t w;
    w.a = a;
    w.d = d;
    w.s = s;
    exp_q.push_back(w);
  endtask

  task automatic monitor();
    wr_t e;
    forever begin
      @(negedge clk);
      if (glb_wr_valid && glb_wr_ready) begin
        if (exp_q.size() == 0) begin
          total_cnt++;
          $display("FAIL unexpected_wr: got addr 0x%0h data 0x%0h, expected no write", glb_wr_addr, glb_wr_data);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", 64'(glb_wr_addr), 64'(e.a));
          check("wr_data", 64'(glb_wr_data), 64'(e.d));
          check("wr_strb", 64'(glb_wr_strb), 64'(e.s));
        end
      end
    end
  endtask

  task automatic wait_drain(input int max);
    int n = 0;
    while (exp_q.size() != 0 && n < max) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", 64'(exp_q.size()), 64'd0);
    repeat (2) tick();
  endtask

  task automatic wait_valid(input int max);
    int n = 0;
    @(negedge clk);
    while (!glb_wr_valid && n < max) begin
      @(negedge clk);
      n++;
    end
    check("valid_timeout", 64'(glb_wr_valid), 64'd1);
  endtask

  task automatic wait_done(input int max);
    int n = 0;
    @(negedge clk);
    while (!done && n < max) begin
      @(negedge clk);
      n++;
    end
    check("done_pulse", 64'(done), 64'd1);
    check("done_busy", 64'(busy), 64'd1);
    tick();
    @(negedge clk);
    check("done_clear", 64'(done), 64'd0);
    check("idle_busy", 64'(busy), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected summary earlier");
    $fatal(1);
  end

  initial begin
    rst          = 1'b1;
    start        = 1'b0;
    flush        = 1'b0;
    glb_wr_ready = 1'b1;
    base_a[0] = 32'h100;
    base_a[1] = 32'h1000;
    base_a[2] = 32'h202;
    base_a[3] = 32'h3000;
    fork
      monitor();
    join_none

    // reset state
    repeat (3) tick();
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_pop_en", 64'(fifo_pop_en), 64'd0);
    check("rst_valid", 64'(glb_wr_valid), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_data", 64'(glb_wr_data), 64'd0);
    tick();
    rst = 1'b0;

    // FIFO0 full, aligned: one 32-bit write, 3 cycles after ARB
    expect_wr(32'h100, 32'h2222_1111, 4'hF);
    push(4'b0001, {16'h0, 16'h0, 16'h0, 16'h1111});
    push(4'b0001, {16'h0, 16'h0, 16'h0, 16'h2222});
    start = 1'b1;
    tick();
    start = 1'b0;
    @(negedge clk);
    check("arb_busy", 64'(busy), 64'd1);
    check("arb_pop_en", 64'(fifo_pop_en), 64'd0);
    tick();
    @(negedge clk);
    check("pop_en", 64'(fifo_pop_en), 64'h1);
    check("pop_mod", 64'(fifo_pop_mod), 64'h1);
    tick();
    @(negedge clk);
    check("latch_valid", 64'(glb_wr_valid), 64'd0);
    tick();
    @(negedge clk);
    check("write_valid_t3", 64'(glb_wr_valid), 64'd1);
    tick();
    @(negedge clk);
    check("post_wr_valid", 64'(glb_wr_valid), 64'd0);
    check("post_wr_busy", 64'(busy), 64'd1);

    // start outside IDLE must not reload addresses: next ch0 word lands at 0x104
    start = 1'b1;
    tick();
    start = 1'b0;
    expect_wr(32'h104, 32'h4444_3333, 4'hF);
    push(4'b0001, {16'h0, 16'h0, 16'h0, 16'h3333});
    push(4'b0001, {16'h0, 16'h0, 16'h0, 16'h4444});
    wait_drain(40);

    // round robin: ch1 alone (rr -> 2), then ch1+ch3 -> 3 first, then ch0+ch3 -> 3 first
    expect_wr(32'h1000, 32'h1B1B_1A1A, 4'hF);
    push(4'b0010, {16'h0, 16'h0, 16'h1A1A, 16'h0});
    push(4'b0010, {16'h0, 16'h0, 16'h1B1B, 16'h0});
    wait_drain(40);
    expect_wr(32'h3000, 32'h5454_5353, 4'hF);
    expect_wr(32'h1004, 32'h5252_5151, 4'hF);
    push(4'b1010, {16'h5353, 16'h0, 16'h5151, 16'h0});
    push(4'b1010, {16'h5454, 16'h0, 16'h5252, 16'h0});
    wait_drain(60);
    expect_wr(32'h3004, 32'h5656_5555, 4'hF);
    expect_wr(32'h108,  32'h5858_5757, 4'hF);
    push(4'b1001, {16'h5555, 16'h0, 16'h0, 16'h5757});
    push(4'b1001, {16'h5656, 16'h0, 16'h0, 16'h5858});
    wait_drain(60);

    // misaligned ch2: 16-bit upper half, stalled 5 cycles; then flush drains the leftover
    glb_wr_ready = 1'b0;
    expect_wr(32'h200, 32'hAAAA_0000, 4'hC);
    expect_wr(32'h204, 32'h0000_BBBB, 4'h3);
    push(4'b0100, {16'h0, 16'hAAAA, 16'h0, 16'h0});
    push(4'b0100, {16'h0, 16'hBBBB, 16'h0, 16'h0});
    wait_valid(20);
    for (int k = 0; k < 5; k++) begin
      check("stall_valid", 64'(glb_wr_valid), 64'd1);
      check("stall_addr", 64'(glb_wr_addr), 64'h200);
      check("stall_data", 64'(glb_wr_data), 64'hAAAA_0000);
      check("stall_strb", 64'(glb_wr_strb), 64'hC);
      tick();
      if (k < 4) @(negedge clk);
    end
    glb_wr_ready = 1'b1;
    flush        = 1'b1;
    wait_done(40);
    check("sb_empty", 64'(exp_q.size()), 64'd0);
`ifdef OPSUM_DRAIN_PERF_EN
    check("perf_stall", 64'(perf_stall_cnt), 64'd5);
    check("perf_words", 64'(perf_word_cnt), 64'd9);
`endif

    // reset while in POP, then restart with a new base
    flush = 1'b0;
    push(4'b0001, {16'h0, 16'h0, 16'h0, 16'h7777});
    push(4'b0001, {16'h0, 16'h0, 16'h0, 16'h8888});
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    @(negedge clk);
    check("pre_rst_pop_en", 64'(fifo_pop_en), 64'h1);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("midpop_rst_pop_en", 64'(fifo_pop_en), 64'd0);
    check("midpop_rst_valid", 64'(glb_wr_valid), 64'd0);
    check("midpop_rst_busy", 64'(busy), 64'd0);
    check("midpop_rst_data", 64'(glb_wr_data), 64'd0);
    check("midpop_rst_strb", 64'(glb_wr_strb), 64'd0);
`ifdef OPSUM_DRAIN_PERF_EN
    check("rst_perf_stall", 64'(perf_stall_cnt), 64'd0);
    check("rst_perf_words", 64'(perf_word_cnt), 64'd0);
`endif
    tick();
    base_a[0] = 32'h500;
    expect_wr(32'h500, 32'h9292_9191, 4'hF);
    push(4'b0001, {16'h0, 16'h0, 16'h0, 16'h9191});
    push(4'b0001, {16'h0, 16'h0, 16'h0, 16'h9292});
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_drain(40);
`ifdef OPSUM_DRAIN_PERF_EN
    check("restart_perf_stall", 64'(perf_stall_cnt), 64'd0);
    check("restart_perf_words", 64'(perf_word_cnt), 64'd1);
`endif
    flush = 1'b1;
    wait_done(20);
    flush = 1'b0;
    check("final_sb_empty", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/opsum_drain_ctrl.md
# opsum_drain_ctrl

Round-robin drain controller for the per-PE opsum FIFOs of the CONV unit. It watches `NUM_CH` 2-entry, 16-bit opsum FIFOs and pops them into a single 32-bit GLB write port. Two partial sums are packed per word when a FIFO is full and the channel's address is word-aligned. A flush phase drains leftover single entries as halfword writes. It sits between the PE array's opsum FIFOs and the GLB write arbiter.

## Interface
- `NUM_CH`, 4: number of opsum FIFOs served (2..16).
- `ADDR_W`, 32: GLB byte-address width.

- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `start` in 1: one-cycle pulse in IDLE; loads address counters and begins draining.
- `flush` in 1: level; when high, non-full, non-empty FIFOs also become eligible.
- `ch_base_addr` in `NUM_CH*ADDR_W`: per-channel start byte address, halfword-aligned (bit0 = 0); sampled on `start`.
- `fifo_full` in `NUM_CH`: FIFO full flags.
- `fifo_empty` in `NUM_CH`: FIFO empty flags.
- `fifo_pop_en` out `NUM_CH`: one-hot pop strobe.
- `fifo_pop_mod` out `NUM_CH`: per-FIFO pop mode. 0 = 16-bit, 1 = 32-bit.
- `fifo_pop_data` in `NUM_CH*32`: FIFO registered pop data, valid the cycle after the pop. In 32-bit mode the older element is in [15:0].
- `glb_wr_valid` out 1: write request.
- `glb_wr_ready` in 1: GLB accepts.
- `glb_wr_addr` out `ADDR_W`: word-aligned byte address (bits[1:0] = 0).
- `glb_wr_data` out 32: write data.
- `glb_wr_strb` out 4: byte strobes.
- `busy` out 1: high in any state except IDLE.
- `done` out 1: one-cycle pulse when flush drain completes.

## Operation
- States: IDLE, ARB, POP, LATCH, WRITE.
- IDLE:
  - On `start`, load `addr[i] = ch_base_addr[i]` and move to ARB.
  - `start` outside IDLE is ignored.
- Eligibility for channel i: `fifo_full[i]`, or `flush && !fifo_empty[i]`.
- ARB:
  - Picks the first eligible channel at or after `rr_ptr`, wrapping modulo `NUM_CH`.
  - Latches the grant and the mode: 32-bit if `fifo_full[i] && addr[i][1]==0`, else 16-bit. Moves to POP.
  - A full FIFO with a halfword-misaligned address pops 16-bit once, which realigns it.
  - If nothing is eligible and `flush` is high, pulse `done` and go to IDLE.
  - If nothing is eligible and `flush` is low, stay in ARB.
- POP: `fifo_pop_en[g]=1` and `fifo_pop_mod[g]`=latched mode, for exactly one cycle. This is a Moore output. Go to LATCH.
- LATCH: capture `fifo_pop_data[g]` into the write-data register and form the address/strobe. Go to WRITE.
- Write formatting:
  - 32-bit: data = pop_data, strb = 1111.
  - 16-bit with `addr[1]==0`: data = {16'd0, pop_data[15:0]}, strb = 0011.
  - 16-bit with `addr[1]==1`: data = {pop_data[15:0], 16'd0}, strb = 1100.
  - `glb_wr_addr = {addr[g][ADDR_W-1:2], 2'b00}`.
- WRITE:
  - `glb_wr_valid=1`; addr/data/strb hold stable until `glb_wr_ready`.
  - On handshake: `addr[g] += 4` (32-bit) or `+= 2` (16-bit), wrapping modulo 2^ADDR_W. Then `rr_ptr = (g+1) mod NUM_CH` and go to ARB.
- Pushes into a FIFO between ARB and POP do not change the latched mode.
- Only this block pops the FIFOs.

## Timing
- Reset: the first rising edge with `rst` high returns the block to IDLE from any state, including mid-POP or mid-WRITE.
  - All outputs are 0.
  - `rr_ptr`, `addr[]`, and the data register are cleared.
  - An in-flight write is dropped.
- Per-transfer latency: eligible in ARB at cycle t, `fifo_pop_en` at t+1, `glb_wr_valid` first high at t+3. With ready already high, the next ARB is at t+4.
- Peak throughput: one GLB write per 4 cycles.
- `done` is asserted in the ARB cycle where `flush` is high and no channel is eligible. Back in IDLE on the next cycle.
- `flush` is sampled only in ARB. Deasserting it mid-transfer does not abort the transfer.

## Configuration
- `OPSUM_DRAIN_PERF_EN` defined: adds outputs `perf_stall_cnt` (32) and `perf_word_cnt` (32).
  - `perf_stall_cnt` counts cycles with `glb_wr_valid && !glb_wr_ready`.
  - `perf_word_cnt` counts accepted writes.
  - Both saturate at all-ones and clear on `rst` and on `start`.
- Undefined: the ports and counters are absent. Functional behaviour is identical.

## Test plan
- NUM_CH=4, base[0]=0x100, FIFO0 full with 0x1111 (older) then 0x2222, ready=1.
  - Expect pop_en[0]=1 with pop_mod=1.
  - Expect a write 3 cycles after ARB: addr 0x100, data 0x22221111, strb 1111.
  - addr[0] becomes 0x104.
- FIFO1 and FIFO3 both full, rr_ptr=2: FIFO3 is served first, then FIFO1; rr_ptr ends at 2.
- base[2]=0x202, FIFO2 full (0xAAAA, 0xBBBB):
  - First write: 16-bit, addr 0x200, data 0xAAAA0000, strb 1100.
  - Then 0xBBBB with flush: addr 0x204, data 0x0000BBBB, strb 0011.
- Ready held low 5 cycles during WRITE: valid/addr/data/strb stable for all 5 cycles; perf_stall_cnt = 5 (if enabled).
- flush=1 with all FIFOs empty in ARB: done pulses for one cycle, then IDLE with busy=0.
- rst asserted while in POP: at the next edge pop_en=0, glb_wr_valid=0, busy=0. A subsequent start reloads base addresses.
